// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator between the core and a single-port word memory.
// Sub-word stores are done as read-modify-write; loads extend the selected lane.
module mem_lsu #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t      state, next_state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    // Flag misaligned, illegal-size or out-of-range requests at acceptance
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        else if (req_size == 2'b01 && req_addr[0])
            req_err = 1'b1;
        else if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        load_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
        load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_ext = unsigned_q ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Replace only the addressed byte or half of the captured word
    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = merge_q;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // State register; reset aborts any request so a pending write cannot happen
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state selection and memory/response outputs decoded from the state
    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_error  = 1'b0;
        mem_address = 32'b0;
        mem_wdata   = 32'b0;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        next_state = RESP;
                    else if (!req_we)
                        next_state = LOAD;
                    else if (req_size == 2'b10)
                        next_state = STORE;
                    else
                        next_state = RMW_RD;
                end
            end
            LOAD: begin
                mem_address = {addr_q[31:2], 2'b00};
                next_state  = RESP;
            end
            STORE: begin
                mem_address = {addr_q[31:2], 2'b00};
                mem_wdata   = wdata_q;
                mem_we      = 1'b1;
                next_state  = RESP;
            end
            RMW_RD: begin
                mem_address = {addr_q[31:2], 2'b00};
                next_state  = RMW_WR;
            end
            RMW_WR: begin
                mem_address = {addr_q[31:2], 2'b00};
                mem_wdata   = merged;
                mem_we      = 1'b1;
                next_state  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture request fields on acceptance and the old word during RMW_RD
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            size_q     <= 2'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            merge_q    <= 32'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                err_q      <= req_err;
            end
            if (state == RMW_RD)
                merge_q <= mem_rdata;
        end
    end

    // Response data changes only when a new response is about to be issued
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rdata_q <= 32'b0;
        else if (next_state == RESP && state != RESP)
            rdata_q <= (state == LOAD) ? load_ext : 32'b0;
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with a word memory model.
module tb_mem_lsu;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:4095];
    logic        preload_en;
    logic [11:0] preload_idx;
    logic [31:0] preload_data;

    int checks;
    int failures;

    mem_lsu dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on rising edge
    assign mem_rdata = mem[mem_address[13:2]];

    always @(posedge clk) begin
        if (preload_en)
            mem[preload_idx] <= preload_data;
        else if (mem_we)
            mem[mem_address[13:2]] <= mem_wdata;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
        @(negedge clk);
        preload_en   = 1'b1;
        preload_idx  = byte_addr[13:2];
        preload_data = data;
        @(posedge clk);
        #1 preload_en = 1'b0;
    endtask

    // Issue one request, follow it to its response and check latency/data/memory traffic
    task automatic apply_stimulus(input string tag, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                                  input bit hold, input int exp_lat, input logic [31:0] exp_rdata,
                                  input logic exp_err, input int exp_we_cnt, input logic [31:0] exp_we_addr);
        int          cyc;
        int          lat;
        int          we_cnt;
        logic [31:0] we_addr;
        logic        rdy_high;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        check_output({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        cyc      = 1;
        lat      = 0;
        we_cnt   = 0;
        we_addr  = 32'b0;
        rdy_high = 1'b0;
        rd       = 32'hxxxx_xxxx;
        er       = 1'bx;
        while (lat == 0 && cyc <= 8) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_address;
            end
            if (req_ready) rdy_high = 1'b1;
            if (resp_valid) begin
                lat = cyc;
                rd  = resp_rdata;
                er  = resp_error;
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        check_output({tag, "_latency"}, lat, exp_lat);
        check_output({tag, "_rdata"}, rd, exp_rdata);
        check_output({tag, "_error"}, {31'b0, er}, {31'b0, exp_err});
        check_output({tag, "_we_count"}, we_cnt, exp_we_cnt);
        check_output({tag, "_busy_ready"}, {31'b0, rdy_high}, 32'd0);
        if (exp_we_cnt > 0)
            check_output({tag, "_we_addr"}, we_addr, exp_we_addr);
    endtask

    initial begin
        int stray;
        checks       = 0;
        failures     = 0;
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'b0;
        req_wdata    = 32'b0;
        req_size     = 2'b0;
        req_unsigned = 1'b0;
        preload_en   = 1'b0;
        preload_idx  = 12'b0;
        preload_data = 32'b0;

        preload(32'h200, 32'h1122_3344);
        preload(32'h204, 32'h1122_3344);
        preload(32'h300, 32'h5555_5555);

        @(negedge clk);
        check_output("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check_output("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check_output("rst_mem_address", mem_address, 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_mem_we", {31'b0, mem_we}, 32'd0);
        resetn = 1'b1;

        // Word store then load
        apply_stimulus("sw_100", 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 2, 32'h0, 1'b0, 1, 32'h100);
        check_output("mem_100", mem[32'h100 >> 2], 32'hDEAD_BEEF);
        apply_stimulus("lw_100", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
        @(negedge clk);
        check_output("rdata_hold", resp_rdata, 32'hDEAD_BEEF);
        check_output("resp_pulse", {31'b0, resp_valid}, 32'd0);

        // Byte read-modify-write and signed/unsigned byte loads
        apply_stimulus("sb_202", 1'b1, 32'h202, 32'h0000_00AA, 2'b00, 1'b0, 1'b0, 3, 32'h0, 1'b0, 1, 32'h200);
        check_output("mem_200", mem[32'h200 >> 2], 32'h11AA_3344);
        apply_stimulus("lb_202", 1'b0, 32'h202, 32'h0, 2'b00, 1'b0, 1'b0, 2, 32'hFFFF_FFAA, 1'b0, 0, 32'h0);
        apply_stimulus("lbu_202", 1'b0, 32'h202, 32'h0, 2'b00, 1'b1, 1'b0, 2, 32'h0000_00AA, 1'b0, 0, 32'h0);

        // Half read-modify-write and half loads from both lanes
        apply_stimulus("sh_206", 1'b1, 32'h206, 32'h0000_8001, 2'b01, 1'b0, 1'b0, 3, 32'h0, 1'b0, 1, 32'h204);
        check_output("mem_204", mem[32'h204 >> 2], 32'h8001_3344);
        apply_stimulus("lh_206", 1'b0, 32'h206, 32'h0, 2'b01, 1'b0, 1'b0, 2, 32'hFFFF_8001, 1'b0, 0, 32'h0);
        apply_stimulus("lh_204", 1'b0, 32'h204, 32'h0, 2'b01, 1'b0, 1'b0, 2, 32'h0000_3344, 1'b0, 0, 32'h0);

        // Error cases respond after one cycle with no memory write
        apply_stimulus("err_lw_101", 1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 1'b0, 1, 32'h0, 1'b1, 0, 32'h0);
        apply_stimulus("err_sh_203", 1'b1, 32'h203, 32'h1234, 2'b01, 1'b0, 1'b0, 1, 32'h0, 1'b1, 0, 32'h0);
        apply_stimulus("err_size11", 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b1, 0, 32'h0);
        apply_stimulus("err_lw_4000", 1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, 1'b0, 1, 32'h0, 1'b1, 0, 32'h0);
        check_output("mem_200_err", mem[32'h200 >> 2], 32'h11AA_3344);

        // Reset while the sub-word store is in RMW_RD
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h300;
        req_wdata    = 32'h0000_00AA;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        check_output("abort_mem_we", {31'b0, mem_we}, 32'd0);
        check_output("abort_ready", {31'b0, req_ready}, 32'd1);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) resetn = 1'b1;
            if (resp_valid || mem_we) stray++;
        end
        check_output("abort_no_activity", stray, 0);
        check_output("abort_mem_300", mem[32'h300 >> 2], 32'h5555_5555);
        check_output("abort_ready_after", {31'b0, req_ready}, 32'd1);

        // Back-to-back requests with req_valid held high
        apply_stimulus("b2b_sw", 1'b1, 32'h400, 32'h1234_5678, 2'b10, 1'b0, 1'b1, 2, 32'h0, 1'b0, 1, 32'h400);
        apply_stimulus("b2b_lbu", 1'b0, 32'h401, 32'h0, 2'b00, 1'b1, 1'b1, 2, 32'h0000_0056, 1'b0, 0, 32'h0);
        apply_stimulus("b2b_sh", 1'b1, 32'h400, 32'h0000_BEEF, 2'b01, 1'b0, 1'b1, 3, 32'h0, 1'b0, 1, 32'h400);
        apply_stimulus("b2b_lw", 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 1'b1, 2, 32'h1234_BEEF, 1'b0, 0, 32'h0);
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
